// File: rtl/rtc_calendar_core.sv
// Time-of-day and calendar counter: divides CLK to a 1 s tick and keeps
// sec/min/hour and day/month/year with leap-year handling and validated loads.
module rtc_calendar_core #(
  parameter int unsigned TICK_DIV  = 100,
  parameter int unsigned RST_YEAR  = 16,
  parameter int unsigned RST_MONTH = 12,
  parameter int unsigned RST_DAY   = 2
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        HOLD,
  input  logic        MODE_12H,
  input  logic        LOAD_TIME,
  input  logic [16:0] IN_TIME,
  input  logic        LOAD_DATE,
  input  logic [15:0] IN_DATE,
  output logic [17:0] OUT_TIME,
  output logic [15:0] OUT_DATE,
  output logic        SEC_PULSE,
  output logic        DAY_PULSE,
  output logic        LOAD_ERR
);

  localparam int unsigned         CNT_W   = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [6:0]          RST_Y   = 7'(RST_YEAR);
  localparam logic [3:0]          RST_M   = 4'(RST_MONTH);
  localparam logic [4:0]          RST_D   = 5'(RST_DAY);

  logic [CNT_W-1:0] cnt;
  logic [5:0]       sec_q, min_q;
  logic [4:0]       hour_q;
  logic [6:0]       year_q;
  logic [3:0]       month_q;
  logic [4:0]       day_q;
  logic             sec_pulse_q, day_pulse_q, load_err_q;

  // Days in a month; 0 marks an invalid month so it also fails day validation.
  function automatic logic [4:0] month_len(input logic [3:0] m, input logic [6:0] y);
    case (m)
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: month_len = 5'd31;
      4'd4, 4'd6, 4'd9, 4'd11:                    month_len = 5'd30;
      4'd2:    month_len = (y[1:0] == 2'd0) ? 5'd29 : 5'd28;
      default: month_len = 5'd0;
    endcase
  endfunction

  logic [4:0] in_hour;
  logic [5:0] in_min, in_sec;
  logic [6:0] in_year;
  logic [3:0] in_month;
  logic [4:0] in_day;
  logic       time_ok, date_ok, time_ld, date_ld;
  logic       tick, tick_eff, day_roll;
  logic [4:0] cur_len;

  always_comb begin
    in_hour  = IN_TIME[16:12];
    in_min   = IN_TIME[11:6];
    in_sec   = IN_TIME[5:0];
    in_year  = IN_DATE[15:9];
    in_month = IN_DATE[8:5];
    in_day   = IN_DATE[4:0];
    time_ok  = (in_hour <= 5'd23) && (in_min <= 6'd59) && (in_sec <= 6'd59);
    date_ok  = (in_month >= 4'd1) && (in_month <= 4'd12) && (in_day >= 5'd1) &&
               (in_day <= month_len(in_month, in_year));
    time_ld  = LOAD_TIME && time_ok;
    date_ld  = LOAD_DATE && date_ok;
    tick     = (cnt == CNT_MAX) && !HOLD;
    // An accepted time load swallows a coincident tick entirely.
    tick_eff = tick && !time_ld;
    day_roll = tick_eff && (sec_q == 6'd59) && (min_q == 6'd59) && (hour_q == 5'd23);
    cur_len  = month_len(month_q, year_q);
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      cnt         <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      hour_q      <= '0;
      year_q      <= RST_Y;
      month_q     <= RST_M;
      day_q       <= RST_D;
      sec_pulse_q <= 1'b0;
      day_pulse_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      sec_pulse_q <= tick_eff;
      day_pulse_q <= day_roll;
      load_err_q  <= (LOAD_TIME && !time_ok) || (LOAD_DATE && !date_ok);

      if (time_ld) begin
        cnt    <= '0;
        hour_q <= in_hour;
        min_q  <= in_min;
        sec_q  <= in_sec;
      end else begin
        if (!HOLD)
          cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
        if (tick_eff) begin
          if (sec_q == 6'd59) begin
            sec_q <= '0;
            if (min_q == 6'd59) begin
              min_q  <= '0;
              hour_q <= (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
            end else begin
              min_q <= min_q + 6'd1;
            end
          end else begin
            sec_q <= sec_q + 6'd1;
          end
        end
      end

      // A loaded date overrides the rollover advance in the same cycle.
      if (date_ld) begin
        year_q  <= in_year;
        month_q <= in_month;
        day_q   <= in_day;
      end else if (day_roll) begin
        if (day_q >= cur_len) begin
          day_q <= 5'd1;
          if (month_q == 4'd12) begin
            month_q <= 4'd1;
            year_q  <= (year_q == 7'd99) ? '0 : year_q + 7'd1;
          end else begin
            month_q <= month_q + 4'd1;
          end
        end else begin
          day_q <= day_q + 5'd1;
        end
      end
    end
  end

  logic [4:0] hour_disp;
  logic       pm;

  always_comb begin
    hour_disp = hour_q;
    pm        = 1'b0;
    if (MODE_12H) begin
      pm = (hour_q >= 5'd12);
      if (hour_q == 5'd0)
        hour_disp = 5'd12;
      else if (hour_q > 5'd12)
        hour_disp = hour_q - 5'd12;
    end
  end

  assign OUT_TIME  = {pm, hour_disp, min_q, sec_q};
  assign OUT_DATE  = {year_q, month_q, day_q};
  assign SEC_PULSE = sec_pulse_q;
  assign DAY_PULSE = day_pulse_q;
  assign LOAD_ERR  = load_err_q;

endmodule

// File: tb/tb_rtc_calendar_core.sv
// Scoreboard bench for rtc_calendar_core with TICK_DIV=4.
module tb_rtc_calendar_core;

  logic        CLK = 1'b0;
  logic        RESETN, HOLD, MODE_12H, LOAD_TIME, LOAD_DATE;
  logic [16:0] IN_TIME;
  logic [15:0] IN_DATE;
  logic [17:0] OUT_TIME;
  logic [15:0] OUT_DATE;
  logic        SEC_PULSE, DAY_PULSE, LOAD_ERR;

  rtc_calendar_core #(.TICK_DIV(4)) dut (
    .CLK(CLK), .RESETN(RESETN), .HOLD(HOLD), .MODE_12H(MODE_12H),
    .LOAD_TIME(LOAD_TIME), .IN_TIME(IN_TIME), .LOAD_DATE(LOAD_DATE), .IN_DATE(IN_DATE),
    .OUT_TIME(OUT_TIME), .OUT_DATE(OUT_DATE),
    .SEC_PULSE(SEC_PULSE), .DAY_PULSE(DAY_PULSE), .LOAD_ERR(LOAD_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [17:0] t;
    logic [15:0] d;
    logic [2:0]  p;  // {SEC_PULSE, DAY_PULSE, LOAD_ERR}
  } exp_t;

  exp_t sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] tm(input int unsigned pm, h, m, s);
    return {1'(pm), 5'(h), 6'(m), 6'(s)};
  endfunction

  function automatic logic [16:0] ti(input int unsigned h, m, s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  function automatic logic [15:0] dt(input int unsigned y, m, d);
    return {7'(y), 4'(m), 5'(d)};
  endfunction

  task automatic push_exp(input string tag, input logic [17:0] t, input logic [15:0] d,
                          input logic [2:0] p);
    exp_t e;
    e.tag = tag; e.t = t; e.d = d; e.p = p;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check_eq({e.tag, "/time"}, 32'(OUT_TIME), 32'(e.t));
    check_eq({e.tag, "/date"}, 32'(OUT_DATE), 32'(e.d));
    check_eq({e.tag, "/pulses"}, 32'({SEC_PULSE, DAY_PULSE, LOAD_ERR}), 32'(e.p));
  endtask

  // Push the expected result of the upcoming edge, clock it, then compare.
  task automatic cycle(input string tag, input logic [17:0] t, input logic [15:0] d,
                       input logic [2:0] p);
    push_exp(tag, t, d, p);
    @(posedge CLK);
    #1;
    compare_out();
  endtask

  // Load 23:59:59 plus a date, then one tick must roll to the next day.
  task automatic roll_test(input string tag, input logic [15:0] din, input logic [15:0] dout);
    LOAD_TIME = 1'b1; IN_TIME = ti(23, 59, 59);
    LOAD_DATE = 1'b1; IN_DATE = din;
    cycle({tag, "_load"}, tm(0, 23, 59, 59), din, 3'b000);
    LOAD_TIME = 1'b0; LOAD_DATE = 1'b0;
    for (int i = 0; i < 3; i++) cycle({tag, "_wait"}, tm(0, 23, 59, 59), din, 3'b000);
    cycle({tag, "_roll"}, tm(0, 0, 0, 0), dout, 3'b110);
  endtask

  localparam logic [15:0] D_RST = {7'd16, 4'd12, 5'd2};

  int unsigned hr[5]  = '{0, 11, 12, 13, 23};
  int unsigned h12[5] = '{12, 11, 12, 1, 11};
  int unsigned pmv[5] = '{0, 0, 1, 1, 1};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] cd;
    RESETN = 1'b0; HOLD = 1'b0; MODE_12H = 1'b0;
    LOAD_TIME = 1'b0; LOAD_DATE = 1'b0; IN_TIME = '0; IN_DATE = '0;
    #1;
    cycle("reset", tm(0, 0, 0, 0), D_RST, 3'b000);
    RESETN = 1'b1;

    for (int i = 1; i <= 12; i++)
      cycle("count", tm(0, 0, 0, i / 4), D_RST, {(i % 4) == 0, 2'b00});

    roll_test("leap",   dt(16, 2, 28),  dt(16, 2, 29));
    roll_test("noleap", dt(17, 2, 28),  dt(17, 3, 1));
    roll_test("y99",    dt(99, 12, 31), dt(0, 1, 1));
    cycle("daypulse_off", tm(0, 0, 0, 0), dt(0, 1, 1), 3'b000);

    // Date load coinciding with a midnight rollover (cnt: 1 -> ... tick on 3rd edge).
    LOAD_TIME = 1'b1; IN_TIME = ti(23, 59, 59);
    cycle("sim_load", tm(0, 23, 59, 59), dt(0, 1, 1), 3'b000);
    LOAD_TIME = 1'b0;
    for (int i = 0; i < 3; i++) cycle("sim_wait", tm(0, 23, 59, 59), dt(0, 1, 1), 3'b000);
    LOAD_DATE = 1'b1; IN_DATE = dt(20, 6, 15);
    cycle("sim_roll", tm(0, 0, 0, 0), dt(20, 6, 15), 3'b110);
    LOAD_DATE = 1'b0;
    cd = dt(20, 6, 15);

    // Rejected loads: state unchanged, counting continues.
    LOAD_TIME = 1'b1; IN_TIME = ti(5, 0, 0);
    cycle("ld_5h", tm(0, 5, 0, 0), cd, 3'b000);
    IN_TIME = ti(24, 0, 0);
    cycle("bad_hour", tm(0, 5, 0, 0), cd, 3'b001);
    LOAD_TIME = 1'b0; LOAD_DATE = 1'b1; IN_DATE = dt(17, 2, 29);
    cycle("bad_feb29", tm(0, 5, 0, 0), cd, 3'b001);
    IN_DATE = dt(17, 4, 31);
    cycle("bad_apr31", tm(0, 5, 0, 0), cd, 3'b001);
    LOAD_DATE = 1'b0;
    cycle("tick_after_err", tm(0, 5, 0, 1), cd, 3'b100);
    LOAD_TIME = 1'b1; IN_TIME = ti(1, 2, 3);
    LOAD_DATE = 1'b1; IN_DATE = dt(17, 13, 1);
    cycle("mixed_load", tm(0, 1, 2, 3), cd, 3'b001);
    LOAD_TIME = 1'b0; LOAD_DATE = 1'b0;
    cycle("idle", tm(0, 1, 2, 3), cd, 3'b000);

    // HOLD freezes counters and divider (divider parked at 1).
    HOLD = 1'b1;
    for (int i = 0; i < 20; i++) cycle("hold", tm(0, 1, 2, 3), cd, 3'b000);
    HOLD = 1'b0;
    cycle("unhold_a", tm(0, 1, 2, 3), cd, 3'b000);
    cycle("unhold_b", tm(0, 1, 2, 3), cd, 3'b000);
    cycle("unhold_tick", tm(0, 1, 2, 4), cd, 3'b100);

    HOLD = 1'b1; LOAD_TIME = 1'b1; IN_TIME = ti(10, 20, 30);
    cycle("hold_load", tm(0, 10, 20, 30), cd, 3'b000);
    LOAD_TIME = 1'b0;
    for (int i = 0; i < 5; i++) cycle("hold2", tm(0, 10, 20, 30), cd, 3'b000);
    HOLD = 1'b0;
    for (int i = 0; i < 3; i++) cycle("run2", tm(0, 10, 20, 30), cd, 3'b000);
    cycle("run2_tick", tm(0, 10, 20, 31), cd, 3'b100);

    // 12 h display mapping, then back to 24 h.
    for (int i = 0; i < 5; i++) begin
      MODE_12H = 1'b1; LOAD_TIME = 1'b1; IN_TIME = ti(hr[i], 34, 56);
      cycle("mode12", tm(pmv[i], h12[i], 34, 56), cd, 3'b000);
      LOAD_TIME = 1'b0; MODE_12H = 1'b0;
      #1;
      push_exp("mode24", tm(0, hr[i], 34, 56), cd, 3'b000);
      compare_out();
    end

    // Load on the tick cycle: no increment, divider restarts.
    for (int i = 0; i < 3; i++) cycle("pre_tick", tm(0, 23, 34, 56), cd, 3'b000);
    LOAD_TIME = 1'b1; IN_TIME = ti(7, 8, 9);
    cycle("load_on_tick", tm(0, 7, 8, 9), cd, 3'b000);
    LOAD_TIME = 1'b0;
    for (int i = 0; i < 3; i++) cycle("post_load", tm(0, 7, 8, 9), cd, 3'b000);
    cycle("post_load_tick", tm(0, 7, 8, 10), cd, 3'b100);

    // Reset mid-count overrides a tick and both loads.
    for (int i = 0; i < 3; i++) cycle("pre_rst", tm(0, 7, 8, 10), cd, 3'b000);
    RESETN = 1'b0;
    LOAD_TIME = 1'b1; IN_TIME = ti(25, 0, 0);
    LOAD_DATE = 1'b1; IN_DATE = dt(20, 1, 1);
    cycle("mid_reset", tm(0, 0, 0, 0), D_RST, 3'b000);
    RESETN = 1'b1; LOAD_TIME = 1'b0; LOAD_DATE = 1'b0;
    cycle("after_reset", tm(0, 0, 0, 0), D_RST, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
